// File: rtl/fpdiv_ctrl.sv
// ============================================================================
// Module   : fpdiv_ctrl
// Brief    : Moore sequencer for the Goldschmidt divider datapath: IA scaling,
//            N/D refinement pairs, then the remainder/rounding cycle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fpdiv_ctrl #(
    parameter int ITERS = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       rm_in,
    output logic [1:0] sel_mux4,
    output logic [1:0] sel_mux3,
    output logic       en_a,
    output logic       en_b,
    output logic       en_rem,
    output logic       rm,
    output logic [3:0] iter,
    output logic       busy,
    output logic       done
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_NUM0 = 3'd1,
        S_DEN0 = 3'd2,
        S_NUMI = 3'd3,
        S_DENI = 3'd4,
        S_REM  = 3'd5,
        S_DONE = 3'd6
    } state_t;

    localparam logic [3:0] C_ITERS = 4'(ITERS);

    state_t     state_q, state_d;
    logic [3:0] iter_q, iter_d;
    logic       rm_q, rm_d;
    logic [1:0] sel4_q, sel4_d;
    logic [1:0] sel3_q, sel3_d;
    logic       en_a_q, en_a_d;
    logic       en_b_q, en_b_d;
    logic       en_rem_q, en_rem_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    // Sequencing: iter tracks the NUMI/DENI pair index and freezes at ITERS for REM.
    always_comb begin
        state_d = state_q;
        iter_d  = iter_q;
        rm_d    = rm_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_NUM0;
                    iter_d  = 4'd1;
                    rm_d    = rm_in;
                end else begin
                    state_d = S_IDLE;
                    iter_d  = 4'd0;
                end
            end
            S_NUM0: state_d = S_DEN0;
            S_DEN0: begin
                state_d = S_NUMI;
                iter_d  = 4'd2;
            end
            S_NUMI: state_d = S_DENI;
            S_DENI: begin
                if (iter_q == C_ITERS) begin
                    state_d = S_REM;
                end else begin
                    state_d = S_NUMI;
                    iter_d  = iter_q + 4'd1;
                end
            end
            S_REM: begin
                state_d = S_DONE;
                iter_d  = 4'd0;
            end
            default: begin
                state_d = S_IDLE;
                iter_d  = 4'd0;
            end
        endcase
    end

    // Outputs decoded from the next state so they are registered alongside it.
    always_comb begin
        sel4_d   = 2'b00;
        sel3_d   = 2'b00;
        en_a_d   = 1'b0;
        en_b_d   = 1'b0;
        en_rem_d = 1'b0;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        case (state_d)
            S_NUM0: begin
                en_a_d = 1'b1;
                busy_d = 1'b1;
            end
            S_DEN0: begin
                sel4_d = 2'b01;
                en_b_d = 1'b1;
                busy_d = 1'b1;
            end
            S_NUMI: begin
                sel4_d = 2'b10;
                sel3_d = 2'b01;
                en_a_d = 1'b1;
                busy_d = 1'b1;
            end
            S_DENI: begin
                sel4_d = 2'b11;
                sel3_d = 2'b01;
                en_b_d = 1'b1;
                busy_d = 1'b1;
            end
            S_REM: begin
                sel4_d   = 2'b10;
                sel3_d   = 2'b10;
                en_rem_d = 1'b1;
                busy_d   = 1'b1;
            end
            S_DONE:  done_d = 1'b1;
            default: done_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            iter_q   <= 4'd0;
            rm_q     <= 1'b0;
            sel4_q   <= 2'b00;
            sel3_q   <= 2'b00;
            en_a_q   <= 1'b0;
            en_b_q   <= 1'b0;
            en_rem_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            iter_q   <= iter_d;
            rm_q     <= rm_d;
            sel4_q   <= sel4_d;
            sel3_q   <= sel3_d;
            en_a_q   <= en_a_d;
            en_b_q   <= en_b_d;
            en_rem_q <= en_rem_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign sel_mux4 = sel4_q;
    assign sel_mux3 = sel3_q;
    assign en_a     = en_a_q;
    assign en_b     = en_b_q;
    assign en_rem   = en_rem_q;
    assign rm       = rm_q;
    assign iter     = iter_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

`default_nettype wire
